// File: rtl/deser_queue_pkg.sv
// Shared types and helpers for the deser_queue receiver and its FIFO.
package deser_queue_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PUSH    = 2'd1,
    STALL   = 2'd2
  } state_e;

  function automatic int calc_len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Even parity over up to 64 data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/deser_queue_fifo.sv
// Circular first-word-fall-through queue with registered len/full/empty.
module deser_queue_fifo
  import deser_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int LEN_W      = calc_len_w(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [LEN_W-1:0]      len_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full queue is only legal when the same edge frees the head slot.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    len_d    = len_q;
    if (do_push && !do_pop) begin
      len_d = len_q + LEN_W'(1);
    end else if (!do_push && do_pop) begin
      len_d = len_q - LEN_W'(1);
    end
    full_d  = (len_d == LEN_W'(DEPTH));
    empty_d = (len_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign len_o   = len_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/deser_queue.sv
// Serial-to-parallel receiver that pushes each assembled word into a DEPTH-entry FWFT queue.
// Define DESER_PARITY_EN to append an even-parity bit to every serial frame.
module deser_queue
  import deser_queue_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  parameter  int MSB_FIRST  = 1,
  localparam int LEN_W      = calc_len_w(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  write_in,
  output logic                  status_out,
  output logic                  data_ready,
  input  logic                  dequeue_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LEN_W-1:0]      len_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  parity_err_out
);

`ifdef DESER_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  last_bit, space, parity_ok, push_word;
`ifdef DESER_PARITY_EN
  logic                  par_bit_q;
`endif

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] s,
                                                     input logic b);
    return (MSB_FIRST != 0) ? {s[DATA_WIDTH-2:0], b} : {b, s[DATA_WIDTH-1:1]};
  endfunction

  assign last_bit = (cnt_q == CNT_W'(FRAME_BITS - 1));
  assign space    = !full_out || dequeue_in;

`ifdef DESER_PARITY_EN
  assign parity_ok      = (even_parity(64'(shift_q)) == par_bit_q);
  assign parity_err_out = (state_q == PUSH) && !parity_ok;
`else
  assign parity_ok      = 1'b1;
  assign parity_err_out = 1'b0;
`endif

  assign push_word  = (state_q != COLLECT) && parity_ok && space;
  assign data_ready = push_word;
  assign status_out = (state_q == COLLECT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= COLLECT;
      shift_q   <= '0;
      cnt_q     <= '0;
`ifdef DESER_PARITY_EN
      par_bit_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (write_in) begin
            cnt_q <= last_bit ? '0 : cnt_q + CNT_W'(1);
`ifdef DESER_PARITY_EN
            // The trailing parity bit is kept apart so the data word stays aligned.
            if (last_bit) par_bit_q <= data_in;
            else          shift_q   <= shift_in(shift_q, data_in);
`else
            shift_q <= shift_in(shift_q, data_in);
`endif
            if (last_bit) state_q <= PUSH;
          end
        end
        PUSH: begin
          if (!parity_ok || space) state_q <= COLLECT;
          else                     state_q <= STALL;
        end
        STALL: begin
          if (space) state_q <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  deser_queue_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .LEN_W     (LEN_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push_word),
    .push_data_i(shift_q),
    .pop_i      (dequeue_in),
    .head_o     (data_out),
    .len_o      (len_out),
    .full_o     (full_out),
    .empty_o    (empty_out)
  );

endmodule

// File: tb/tb_deser_queue.sv
// Two receivers (MSB-first and LSB-first) share one stimulus stream and one frame-level model.
module tb_deser_queue;

  localparam int W = 8;
  localparam int D = 3;
`ifdef DESER_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic clock = 1'b0, reset = 1'b0, data_in = 1'b0, write_in = 1'b0, dequeue_in = 1'b0;
  logic status_a, status_b, rdy_a, rdy_b, full_a, full_b, empty_a, empty_b, perr_a, perr_b;
  logic [W-1:0] dout_a, dout_b;
  logic [1:0]   len_a, len_b;

  int tests = 0;
  int fails = 0;

  // Frame-level reference: occupancy count, bits of the frame in progress,
  // and a word waiting for queue space.
  int       m_len   = 0;
  bit       m_busy  = 0;
  bit       m_fresh = 0;
  bit       m_par_ok = 1;
  bit       m_bits[$];
  logic [W-1:0] sb_a[$];
  logic [W-1:0] sb_b[$];

  always #5 clock = ~clock;

  deser_queue #(.DATA_WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut_a (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(status_a), .data_ready(rdy_a), .dequeue_in(dequeue_in),
    .data_out(dout_a), .len_out(len_a), .full_out(full_a), .empty_out(empty_a),
    .parity_err_out(perr_a)
  );

  deser_queue #(.DATA_WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut_b (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(status_b), .data_ready(rdy_b), .dequeue_in(dequeue_in),
    .data_out(dout_b), .len_out(len_b), .full_out(full_b), .empty_out(empty_b),
    .parity_err_out(perr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit exp_ready();
    return m_busy && m_par_ok && (m_len < D || (dequeue_in && m_len > 0));
  endfunction

  task automatic check_outputs();
    bit rdy, perr;
    rdy  = exp_ready();
    perr = m_busy && m_fresh && !m_par_ok;
    check("status_a", status_a, !m_busy);
    check("status_b", status_b, !m_busy);
    check("ready_a", rdy_a, rdy);
    check("ready_b", rdy_b, rdy);
    check("perr_a", perr_a, perr);
    check("perr_b", perr_b, perr);
    check("len_a", len_a, m_len);
    check("len_b", len_b, m_len);
    check("full_a", full_a, m_len == D);
    check("empty_a", empty_a, m_len == 0);
    check("empty_b", empty_b, m_len == 0);
    if (m_len == 0) begin
      check("dout_empty_a", dout_a, 0);
      check("dout_empty_b", dout_b, 0);
    end
  endtask

  task automatic frame_done();
    logic [W-1:0] wm, wl;
    bit ok;
    wm = '0;
    wl = '0;
    for (int i = 0; i < W; i++) begin
      wm    = {wm[W-2:0], m_bits[i]};
      wl[i] = m_bits[i];
    end
    ok = 1;
    if (FB > W) ok = ((^wm) == m_bits[W]);
    m_busy   = 1;
    m_fresh  = 1;
    m_par_ok = ok;
    if (ok) begin
      sb_a.push_back(wm);
      sb_b.push_back(wl);
    end
    m_bits.delete();
  endtask

  task automatic model_edge();
    bit push, pop;
    push  = exp_ready();
    pop   = dequeue_in && (m_len > 0);
    m_len = m_len + int'(push) - int'(pop);
    if (m_busy) begin
      if (!m_par_ok || push) m_busy = 0;
      m_fresh = 0;
    end else if (write_in) begin
      m_bits.push_back(data_in);
      if (m_bits.size() == FB) frame_done();
    end
  endtask

  task automatic step(input logic w, input logic d, input logic q);
    @(negedge clock);
    write_in   = w;
    data_in    = d;
    dequeue_in = q;
    #1 check_outputs();
    @(posedge clock);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b0;
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    m_len = 0; m_busy = 0; m_fresh = 0; m_par_ok = 1;
    m_bits.delete(); sb_a.delete(); sb_b.delete();
    #1 check_outputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] v, input bit bad_par);
    for (int g = 0; g < 20 && m_busy; g++) step(1'b0, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) step(1'b1, v[i], 1'b0);
    if (FB > W) step(1'b1, (^v) ^ bad_par, 1'b0);
  endtask

  // Monitor: whenever the consumer pops a presented head, compare with the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset && dequeue_in && !empty_a) begin
        tests++;
        if (sb_a.size() == 0) begin
          fails++;
          $display("FAIL head_a: got %0h with nothing expected", dout_a);
        end else begin
          tests--;
          check("head_a", dout_a, sb_a.pop_front());
        end
      end
      if (reset && dequeue_in && !empty_b) begin
        tests++;
        if (sb_b.size() == 0) begin
          fails++;
          $display("FAIL head_b: got %0h with nothing expected", dout_b);
        end else begin
          tests--;
          check("head_b", dout_b, sb_b.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    send_word(8'hA5, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    send_word(8'h80, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    send_word(8'h11, 0);
    send_word(8'h22, 0);
    send_word(8'h33, 0);
    send_word(8'h55, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);

`ifdef DESER_PARITY_EN
    send_word(8'h03, 0);
    send_word(8'h03, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 4));
      if (m_len > D) check("len_bound", m_len, D);
    end

    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
    check("drain_a", sb_a.size(), 0);
    check("drain_b", sb_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deser_queue.md
Name: deser_queue

Overview:
- Single-clock serial-to-parallel receiver fused with a parametrised circular FIFO.
- Serial bits strobed by write_in are assembled into DATA_WIDTH-bit words. Each completed word is pushed automatically into a DEPTH-entry queue, which the consumer drains with dequeue_in.
- Successor to the separate deserializer/queue pair: one clock domain, generic width/depth, backpressure instead of an ack loop, bit-order selection.

Parameters:
- DATA_WIDTH, 8, word width in bits (>=2).
- DEPTH, 8, FIFO entries (>=2, any integer; need not be a power of 2).
- MSB_FIRST, 1, 1: first received bit ends in data_out[DATA_WIDTH-1]; 0: first bit ends in bit 0.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial data bit, sampled when write_in=1 and status_out=1.
- write_in  input  1  bit strobe, one bit per cycle.
- status_out  output  1  1 = deserializer accepts a bit this cycle.
- data_ready  output  1  one-cycle pulse when a word is written into the FIFO.
- dequeue_in  input  1  pop head entry at this edge.
- data_out  output  DATA_WIDTH  FIFO head (first-word-fall-through); 0 when empty.
- len_out  output  LEN_W  current occupancy, LEN_W = $clog2(DEPTH+1) (localparam).
- full_out  output  1  len_out == DEPTH.
- empty_out  output  1  len_out == 0.
- parity_err_out  output  1  one-cycle pulse on parity mismatch (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to COLLECT; shift register, bit counter, pointers and len are cleared.
  - Output reset values: status_out=1, data_ready=0, data_out=0, len_out=0, full_out=0, empty_out=1, parity_err_out=0.
  - A partial word in flight is discarded. Reset release is synchronous to clock.
- FSM states COLLECT, PUSH, STALL:
  - COLLECT: status_out=1. Each write_in shifts data_in in (direction per MSB_FIRST) and increments the bit counter. On the last bit of a frame (counter = FRAME_BITS-1, where FRAME_BITS = DATA_WIDTH without the macro) -> PUSH; counter returns to 0.
  - PUSH: status_out=0. If the FIFO is not full, or full with dequeue_in=1 in the same cycle: write word at wr_ptr, data_ready=1 for this cycle, -> COLLECT. Otherwise -> STALL.
  - STALL: status_out=0, word held. Exit as in PUSH once space exists.
  - write_in while status_out=0: ignored, no state change.
- Word-to-FIFO latency: the word is visible at data_out (if the FIFO was empty) one cycle after the PUSH cycle. Last bit accepted at edge N -> data_ready high in cycle N+1 -> data_out valid after edge N+1.
- FIFO:
  - wr_ptr/rd_ptr wrap from DEPTH-1 to 0.
  - dequeue_in when empty is ignored: len stays 0, no pointer move.
  - Push and pop in the same cycle: both pointers advance, len unchanged. Allowed when full (the pop frees the slot) and when at len=1.
  - When empty, a push cannot bypass to data_out in the same cycle.
- len_out, full_out and empty_out are registered and update at the same edge as the pointers.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - FRAME_BITS = DATA_WIDTH+1; the final serial bit is an even-parity bit over the data bits.
  - On mismatch, the FSM returns to COLLECT without pushing. parity_err_out=1 for that cycle, data_ready stays 0, len unchanged.
  - On match, behaviour is as in PUSH.
- Not defined: FRAME_BITS = DATA_WIDTH; parity_err_out is tied 0. The port list is identical in both builds.

Decomposition:
- Package deser_queue_pkg holds:
  - the FSM state enum (COLLECT, PUSH, STALL);
  - a function computing LEN_W from DEPTH;
  - an even-parity helper function.
- One sub-module, deser_queue_fifo (storage, pointers, len/full/empty), with the FSM and shift register in the top.

Test Plan:
- Reset mid-frame: send 5 bits, assert reset=0 for 1 cycle -> status_out=1, len_out=0, empty_out=1. Then send 8 bits of 0xA5 -> data_ready pulse, data_out=0xA5, len_out=1.
- Bit order: MSB_FIRST=0, send bits 1,0,0,0,0,0,0,0 -> data_out=0x01. MSB_FIRST=1, same bits -> data_out=0x80.
- Full/backpressure: DEPTH=4, push 0x11,0x22,0x33,0x44 -> full_out=1. Send 8 bits of 0x55 -> status_out=0 (STALL), extra write_in ignored. Dequeue once -> 0x55 enters, data_out=0x22, len_out=4.
- Simultaneous push+pop at full and wrap-around: DEPTH=3, cycle 10 words while dequeuing -> output order equals input order, len_out never exceeds 3.
- Empty dequeue: dequeue_in=1 for 3 cycles at reset state -> len_out=0, data_out=0, no X.
- DESER_PARITY_EN: send 0x03 with parity 0 -> pushed. Send 0x03 with parity 1 -> parity_err_out pulse, len_out unchanged, no data_ready.
